// File: rtl/pwm_duty_monitor.sv
// Two-channel PWM duty-cycle and rising-edge monitor.
// Counts per 2^C_PWM_WIDTH-clock window, results strobed by valid_o.
module pwm_duty_monitor #(
  parameter int unsigned C_PWM_WIDTH = 24
) (
  input  logic                   pwm_clk_i,
  input  logic                   pwm_rst_i,
  input  logic [1:0]             pwm_i,
  output logic [C_PWM_WIDTH-1:0] duty0_o,
  output logic [C_PWM_WIDTH-1:0] duty1_o,
  output logic [C_PWM_WIDTH-1:0] rises0_o,
  output logic [C_PWM_WIDTH-1:0] rises1_o,
  output logic [1:0]             sat_o,
  output logic                   valid_o
);

  localparam int unsigned W = C_PWM_WIDTH;

  logic [1:0]   sync1;
  logic [1:0]   sync2;
  logic [1:0]   s;
  logic [1:0]   s_prev;
  logic [1:0]   rise;
  logic [W-1:0] win_cnt;
  logic         tc;
  logic [W:0]   hi0;
  logic [W:0]   hi1;
  logic [W:0]   rise0;
  logic [W:0]   rise1;
  logic [W:0]   hi0_nxt;
  logic [W:0]   hi1_nxt;
  logic [W:0]   rise0_nxt;
  logic [W:0]   rise1_nxt;

  // Clamp a window total to the output width.
  function automatic logic [W-1:0] clip(input logic [W:0] v);
    clip = v[W] ? {W{1'b1}} : v[W-1:0];
  endfunction

  // Synchronize the async inputs, then register one sample.
  always_ff @(posedge pwm_clk_i) begin
    if (pwm_rst_i) begin
      sync1  <= '0;
      sync2  <= '0;
      s      <= '0;
      s_prev <= '0;
    end else begin
      sync1  <= pwm_i;
      sync2  <= sync1;
      s      <= sync2;
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;
  assign tc   = &win_cnt;

  // Running totals including this cycle's contribution.
  always_comb begin
    hi0_nxt   = hi0 + {{W{1'b0}}, s[0]};
    hi1_nxt   = hi1 + {{W{1'b0}}, s[1]};
    rise0_nxt = rise0 + {{W{1'b0}}, rise[0]};
    rise1_nxt = rise1 + {{W{1'b0}}, rise[1]};
  end

  // Free-running window counter.
  always_ff @(posedge pwm_clk_i) begin
    if (pwm_rst_i) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  // Accumulate; at terminal count restart with no dead cycle.
  always_ff @(posedge pwm_clk_i) begin
    if (pwm_rst_i || tc) begin
      hi0   <= '0;
      hi1   <= '0;
      rise0 <= '0;
      rise1 <= '0;
    end else begin
      hi0   <= hi0_nxt;
      hi1   <= hi1_nxt;
      rise0 <= rise0_nxt;
      rise1 <= rise1_nxt;
    end
  end

  // Latch window results and strobe valid the cycle after TC.
  always_ff @(posedge pwm_clk_i) begin
    if (pwm_rst_i) begin
      duty0_o  <= '0;
      duty1_o  <= '0;
      rises0_o <= '0;
      rises1_o <= '0;
      sat_o    <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= tc;
      if (tc) begin
        duty0_o  <= clip(hi0_nxt);
        duty1_o  <= clip(hi1_nxt);
        rises0_o <= clip(rise0_nxt);
        rises1_o <= clip(rise1_nxt);
        sat_o    <= {hi1_nxt[W], hi0_nxt[W]};
      end
    end
  end

endmodule
